// File: rtl/core_cpu_mul_pkg.sv
// Shared types and constants for the pipelined integer multiplier.
// Optional build macro: MULT_CELL_HI_EN (high-word ops and sign correction).
package core_cpu_mul_pkg;

    typedef enum logic [1:0] {
        MUL_LO  = 2'b00,
        MUL_HUU = 2'b01,
        MUL_HSU = 2'b10,
        MUL_HSS = 2'b11
    } mul_op_e;

    localparam int MUL_LATENCY = 3;

    // Per-stage control payload. Tag and operands are carried beside it
    // because their widths follow the instance parameters. The sign flags
    // only exist when the correction logic that consumes them is built.
    typedef struct packed {
        mul_op_e op;
`ifdef MULT_CELL_HI_EN
        logic    a_neg;
        logic    b_neg;
`endif
    } mul_ctl_t;

endpackage

// File: rtl/core_cpu_mul_pp.sv
// Registered HALF_W x HALF_W unsigned partial-product cell with clock
// enable and synchronous clear.
module core_cpu_mul_pp #(
    parameter int HALF_W = 16
) (
    input  logic                  clk,
    input  logic                  clr_i,
    input  logic                  ce_i,
    input  logic [HALF_W-1:0]     a_i,
    input  logic [HALF_W-1:0]     b_i,
    output logic [2*HALF_W-1:0]   p_o
);

    logic [2*HALF_W-1:0] p_d, p_q;

    // Full-width unsigned product of the two half-words.
    always_comb p_d = {{HALF_W{1'b0}}, a_i} * {{HALF_W{1'b0}}, b_i};

    // Clear wins over enable; hold when the pipeline is stalled.
    always_ff @(posedge clk) begin
        if (clr_i)     p_q <= '0;
        else if (ce_i) p_q <= p_d;
    end

    assign p_o = p_q;

endmodule

// File: rtl/core_cpu_mul_pipe.sv
// Three-stage pipelined integer multiplier (MUL / MULXUU / MULXSU / MULXSS)
// with valid/ready flow control. S1 forms the partial products, S2 sums
// them, S3 selects the word and applies signed high-word correction.
// Optional build macro: MULT_CELL_HI_EN. Without it only MUL is supported;
// high-word ops still flow through but return 0 with out_err set.
module core_cpu_mul_pipe
    import core_cpu_mul_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int TAG_W  = 5
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_op,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic [TAG_W-1:0]  out_tag,
    output logic              out_err
);

    localparam int HALF_W = DATA_W / 2;
`ifdef MULT_CELL_HI_EN
    localparam int NUM_PP = 4;
`else
    localparam int NUM_PP = 3;
`endif

    // All stages move as one; the only back-pressure point is the output.
    logic adv;
    logic [MUL_LATENCY:1] vld_d, vld_q;

    assign in_ready = out_ready || !vld_q[MUL_LATENCY] || !reset_n;
    assign adv      = in_ready;

    // Valid bits shift with the payload on every advance.
    always_comb vld_d = adv ? {vld_q[MUL_LATENCY-1:1], in_valid} : vld_q;

    // Valid shift register; in-flight ops vanish on reset.
    always_ff @(posedge clk) begin
        if (!reset_n) vld_q <= '0;
        else          vld_q <= vld_d;
    end

    // ---------------- S1: partial products ----------------
    // Index: 0 = aL*bL, 1 = aL*bH, 2 = aH*bL, 3 = aH*bH.
    logic [NUM_PP-1:0][HALF_W-1:0]   pp_a, pp_b;
    logic [NUM_PP-1:0][DATA_W-1:0]   pp_p;

    // Route operand halves to each partial-product cell.
    always_comb begin
        pp_a[0] = in_a[HALF_W-1:0];      pp_b[0] = in_b[HALF_W-1:0];
        pp_a[1] = in_a[HALF_W-1:0];      pp_b[1] = in_b[DATA_W-1:HALF_W];
        pp_a[2] = in_a[DATA_W-1:HALF_W]; pp_b[2] = in_b[HALF_W-1:0];
`ifdef MULT_CELL_HI_EN
        pp_a[3] = in_a[DATA_W-1:HALF_W]; pp_b[3] = in_b[DATA_W-1:HALF_W];
`endif
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_PP; gi++) begin : g_pp
            core_cpu_mul_pp #(.HALF_W(HALF_W)) u_pp (
                .clk   (clk),
                .clr_i (!reset_n),
                .ce_i  (adv),
                .a_i   (pp_a[gi]),
                .b_i   (pp_b[gi]),
                .p_o   (pp_p[gi])
            );
        end
    endgenerate

    mul_ctl_t          s1_ctl_d, s1_ctl_q, s2_ctl_q;
    logic [TAG_W-1:0]  s1_tag_q, s2_tag_q;
`ifdef MULT_CELL_HI_EN
    logic [DATA_W-1:0] s1_a_q, s1_b_q, s2_a_q, s2_b_q;
`endif

    // Decode the incoming op and capture operand signs for correction.
    always_comb begin
        s1_ctl_d    = '0;
        s1_ctl_d.op = mul_op_e'(in_op);
`ifdef MULT_CELL_HI_EN
        s1_ctl_d.a_neg = in_a[DATA_W-1];
        s1_ctl_d.b_neg = in_b[DATA_W-1];
`endif
    end

    // S1 side-band registers travelling with the partial products.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            s1_ctl_q <= '0;
            s1_tag_q <= '0;
`ifdef MULT_CELL_HI_EN
            s1_a_q   <= '0;
            s1_b_q   <= '0;
`endif
        end else if (adv) begin
            s1_ctl_q <= s1_ctl_d;
            s1_tag_q <= in_tag;
`ifdef MULT_CELL_HI_EN
            s1_a_q   <= in_a;
            s1_b_q   <= in_b;
`endif
        end
    end

    // ---------------- S2: sum of partial products ----------------
`ifdef MULT_CELL_HI_EN
    logic [DATA_W:0]     s2_mid;
    logic [2*DATA_W-1:0] s2_full_d, s2_full_q;

    // Middle sum keeps its carry so it lands in the high word.
    always_comb begin
        s2_mid    = {1'b0, pp_p[1]} + {1'b0, pp_p[2]};
        s2_full_d = {pp_p[3], pp_p[0]}
                  + ({{(DATA_W-1){1'b0}}, s2_mid} << HALF_W);
    end
`else
    logic [DATA_W-1:0] s2_full_d, s2_full_q;

    // Only the low word is needed, so the middle carry is irrelevant.
    always_comb s2_full_d = pp_p[0] + ((pp_p[1] + pp_p[2]) << HALF_W);
`endif

    // S2 pipeline register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            s2_full_q <= '0;
            s2_ctl_q  <= '0;
            s2_tag_q  <= '0;
`ifdef MULT_CELL_HI_EN
            s2_a_q    <= '0;
            s2_b_q    <= '0;
`endif
        end else if (adv) begin
            s2_full_q <= s2_full_d;
            s2_ctl_q  <= s1_ctl_q;
            s2_tag_q  <= s1_tag_q;
`ifdef MULT_CELL_HI_EN
            s2_a_q    <= s1_a_q;
            s2_b_q    <= s1_b_q;
`endif
        end
    end

    // ---------------- S3: word select and sign correction ----------------
    logic [DATA_W-1:0] res_d, res_q;
    logic [TAG_W-1:0]  tag_q;

`ifdef MULT_CELL_HI_EN
    logic [DATA_W-1:0] hi, corr_a, corr_b;

    // Signed high word = unsigned high word minus the other operand for
    // each negative signed operand (mod 2^DATA_W).
    always_comb begin
        hi     = s2_full_q[2*DATA_W-1:DATA_W];
        corr_a = s2_ctl_q.a_neg ? s2_b_q : '0;
        corr_b = s2_ctl_q.b_neg ? s2_a_q : '0;
        res_d  = '0;
        case (s2_ctl_q.op)
            MUL_LO:  res_d = s2_full_q[DATA_W-1:0];
            MUL_HUU: res_d = hi;
            MUL_HSU: res_d = hi - corr_a;
            MUL_HSS: res_d = hi - corr_a - corr_b;
            default: res_d = '0;
        endcase
    end

    assign out_err = 1'b0;
`else
    logic err_d, err_q;

    // High-word ops are unsupported here: zero result, flagged error.
    always_comb begin
        err_d = (s2_ctl_q.op != MUL_LO);
        res_d = err_d ? '0 : s2_full_q;
    end

    // Error flag register travelling with the result.
    always_ff @(posedge clk) begin
        if (!reset_n)  err_q <= 1'b0;
        else if (adv)  err_q <= err_d;
    end

    assign out_err = err_q;
`endif

    // Output register; holds while the consumer stalls.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            res_q <= '0;
            tag_q <= '0;
        end else if (adv) begin
            res_q <= res_d;
            tag_q <= s2_tag_q;
        end
    end

    assign out_valid  = vld_q[MUL_LATENCY];
    assign out_result = res_q;
    assign out_tag    = tag_q;

endmodule
